ram_store_align: RTL and testbench



---
 rtl/ram_store_align.sv | 125 ++++++++++++
 tb/tb_ram_store_align.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ram_store_align.sv
// Store alignment stage between the CPU memory stage and the banked SPRAM.
// Places a right-aligned store value onto big-endian byte lanes, splitting bus-word crossings into two beats.
module ram_store_align #(
    parameter int NUM_BANKS   = 4,
    parameter int BANK_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter bit ALLOW_SPLIT = 1'b1,
    localparam int BUS_BYTES  = NUM_BANKS * BANK_WIDTH / 8,
    localparam int OFF_W      = $clog2(BUS_BYTES),
    localparam int WADDR_W    = ADDR_WIDTH - OFF_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [1:0]             req_size,
    input  logic [63:0]            req_data,
    output logic                   ram_we,
    output logic [WADDR_W-1:0]     ram_addr,
    output logic [BUS_BYTES-1:0]   ram_be,
    output logic [8*BUS_BYTES-1:0] ram_wdata,
    output logic                   done,
    output logic                   err
);

    // Two bus words side by side plus room for a full 8-byte value before shifting.
    localparam int WIN_BYTES = 2 * BUS_BYTES + 8;
    localparam int SW        = OFF_W + 5;

    typedef enum logic [1:0] {S_IDLE, S_WR, S_LO, S_HI} state_t;

    state_t                   state;
    logic [WADDR_W-1:0]       hi_addr;
    logic [BUS_BYTES-1:0]     hi_be_q;
    logic [8*BUS_BYTES-1:0]   hi_data_q;

    logic [OFF_W-1:0]         off;
    logic [WADDR_W-1:0]       word;
    logic [SW-1:0]            n_bytes;
    logic [SW-1:0]            end_off;
    logic [SW-1:0]            shift;
    logic                     too_big;
    logic                     crossing;
    logic [63:0]              val;
    logic [WIN_BYTES-1:0]     val_be;
    logic [8*WIN_BYTES-1:0]   win_data;
    logic [WIN_BYTES-1:0]     win_be;

    assign req_ready = (state != S_LO);
    assign off       = req_addr[OFF_W-1:0];
    assign word      = req_addr[ADDR_WIDTH-1:OFF_W];

    // Offset o of the double word sits on window lane 2*BUS_BYTES-1-o, so one left
    // shift aligns the value: upper half is the first beat, lower half the second.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        val      = '0;
        val_be   = '0;
        n_bytes  = SW'(1) << req_size;
        end_off  = SW'(off) + n_bytes;
        too_big  = n_bytes > SW'(BUS_BYTES);
        crossing = end_off > SW'(BUS_BYTES);
        shift    = too_big ? '0 : SW'(2 * BUS_BYTES) - end_off;
        for (int i = 0; i < 8; i++) begin
            if (SW'(i) < n_bytes) begin
                val[8*i +: 8] = req_data[8*i +: 8];
                val_be[i]     = 1'b1;
            end
        end
        win_data = {{(8*WIN_BYTES-64){1'b0}}, val} << {shift, 3'b000};
        win_be   = val_be << shift;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the split-beat hold registers are cleared too, so a reset in S_LO leaves nothing stale.
            state     <= S_IDLE;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_be    <= '0;
            ram_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            hi_addr   <= '0;
            hi_be_q   <= '0;
            hi_data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= S_IDLE;
            ram_we    <= 1'b0;
            ram_be    <= '0;
            ram_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            if (state == S_LO) begin
                state     <= S_HI;
                ram_we    <= 1'b1;
                ram_addr  <= hi_addr;
                ram_be    <= hi_be_q;
                ram_wdata <= hi_data_q;
                done      <= 1'b1;
            end else if (req_valid) begin
                if (too_big || (crossing && !ALLOW_SPLIT)) begin
                    err <= 1'b1;
                end else begin
                    ram_we    <= 1'b1;
                    ram_addr  <= word;
                    ram_be    <= win_be[2*BUS_BYTES-1:BUS_BYTES];
                    ram_wdata <= win_data[16*BUS_BYTES-1:8*BUS_BYTES];
                    if (crossing) begin
                        state     <= S_LO;
                        hi_addr   <= word + WADDR_W'(1);
                        hi_be_q   <= win_be[BUS_BYTES-1:0];
                        hi_data_q <= win_data[8*BUS_BYTES-1:0];
                    end else begin
                        state <= S_WR;
                        done  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_store_align.sv
// Directed bench for ram_store_align: default split-enabled instance plus an ALLOW_SPLIT=0 instance.
module tb_ram_store_align;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_valid, a_ready, a_we, a_done, a_err;
    logic [15:0] a_addr;
    logic [1:0]  a_size;
    logic [63:0] a_data, a_wdata;
    logic [12:0] a_raddr;
    logic [7:0]  a_be;

    logic        b_valid, b_ready, b_we, b_done, b_err;
    logic [15:0] b_addr;
    logic [1:0]  b_size;
    logic [63:0] b_data, b_wdata;
    logic [12:0] b_raddr;
    logic [7:0]  b_be;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_store_align u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_valid), .req_ready(a_ready), .req_addr(a_addr),
        .req_size(a_size), .req_data(a_data),
        .ram_we(a_we), .ram_addr(a_raddr), .ram_be(a_be), .ram_wdata(a_wdata),
        .done(a_done), .err(a_err)
    );

    ram_store_align #(.ALLOW_SPLIT(1'b0)) u_dut_ns (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_valid), .req_ready(b_ready), .req_addr(b_addr),
        .req_size(b_size), .req_data(b_data),
        .ram_we(b_we), .ram_addr(b_raddr), .ram_be(b_be), .ram_wdata(b_wdata),
        .done(b_done), .err(b_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_a(input logic v, input logic [15:0] addr, input logic [1:0] size, input logic [63:0] data);
        a_valid = v; a_addr = addr; a_size = size; a_data = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic we, input logic [12:0] addr,
                           input logic [7:0] be, input logic [63:0] wdata, input logic dn);
        check({tag, ".we"},    64'(a_we),    64'(we));
        check({tag, ".addr"},  64'(a_raddr), 64'(addr));
        check({tag, ".be"},    64'(a_be),    64'(be));
        check({tag, ".wdata"}, a_wdata,      wdata);
        check({tag, ".done"},  64'(a_done),  64'(dn));
    endtask

    initial begin
        rst_n = 1'b0;
        set_a(1'b0, 16'h0, 2'd0, 64'h0);
        b_valid = 1'b0; b_addr = '0; b_size = '0; b_data = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check_a("rst", 1'b0, 13'h0, 8'h00, 64'h0, 1'b0);
        check("rst.err",   64'(a_err),   64'h0);
        check("rst.ready", 64'(a_ready), 64'h1);

        // Byte store, offset 5 -> lane 2
        set_a(1'b1, 16'h0005, 2'd0, 64'hAB);
        tick();
        set_a(1'b0, 16'h0, 2'd0, 64'h0);
        check_a("byte", 1'b1, 13'h0, 8'h04, 64'h0000_0000_00AB_0000, 1'b1);

        // Aligned quad followed back-to-back by a long
        set_a(1'b1, 16'h0010, 2'd3, 64'h1122_3344_5566_7788);
        tick();
        set_a(1'b1, 16'h001C, 2'd2, 64'hDEAD_BEEF);
        check_a("quad", 1'b1, 13'h2, 8'hFF, 64'h1122_3344_5566_7788, 1'b1);
        check("quad.ready", 64'(a_ready), 64'h1);
        tick();
        set_a(1'b0, 16'h0, 2'd0, 64'h0);
        check_a("long", 1'b1, 13'h3, 8'h0F, 64'h0000_0000_DEAD_BEEF, 1'b1);
        tick();
        check_a("idle", 1'b0, 13'h3, 8'h00, 64'h0, 1'b0);

        // Split quad at offset 3; a byte request is held during S_LO and must stall
        set_a(1'b1, 16'h0003, 2'd3, 64'h1122_3344_5566_7788);
        tick();
        set_a(1'b1, 16'h0000, 2'd0, 64'h55);
        check_a("split_lo", 1'b1, 13'h0, 8'h1F, 64'h0000_0011_2233_4455, 1'b0);
        check("split_lo.ready", 64'(a_ready), 64'h0);
        tick();
        check_a("split_hi", 1'b1, 13'h1, 8'hE0, 64'h6677_8800_0000_0000, 1'b1);
        check("split_hi.ready", 64'(a_ready), 64'h1);
        tick();
        set_a(1'b0, 16'h0, 2'd0, 64'h0);
        check_a("stalled", 1'b1, 13'h0, 8'h80, 64'h5500_0000_0000_0000, 1'b1);

        // Word store crossing the top of the address space wraps to word 0
        set_a(1'b1, 16'hFFFF, 2'd1, 64'hBEEF);
        tick();
        set_a(1'b0, 16'h0, 2'd0, 64'h0);
        check_a("wrap_lo", 1'b1, 13'h1FFF, 8'h01, 64'h0000_0000_0000_00BE, 1'b0);
        tick();
        check_a("wrap_hi", 1'b1, 13'h0000, 8'h80, 64'hEF00_0000_0000_0000, 1'b1);

        // Non-split instance rejects a crossing long, then accepts a byte
        b_valid = 1'b1; b_addr = 16'h0006; b_size = 2'd2; b_data = 64'hCAFE_F00D;
        tick();
        b_valid = 1'b0;
        check("ns_err.err", 64'(b_err), 64'h1);
        check("ns_err.we",  64'(b_we),  64'h0);
        check("ns_err.done", 64'(b_done), 64'h0);
        check("ns_err.ready", 64'(b_ready), 64'h1);
        b_valid = 1'b1; b_addr = 16'h0001; b_size = 2'd0; b_data = 64'h7F;
        tick();
        b_valid = 1'b0;
        check("ns_next.err",   64'(b_err),   64'h0);
        check("ns_next.we",    64'(b_we),    64'h1);
        check("ns_next.be",    64'(b_be),    64'h40);
        check("ns_next.wdata", b_wdata,      64'h007F_0000_0000_0000);
        check("ns_next.done",  64'(b_done),  64'h1);

        // Reset during S_LO abandons the high beat
        set_a(1'b1, 16'h0006, 2'd2, 64'hCAFE_F00D);
        tick();
        set_a(1'b0, 16'h0, 2'd0, 64'h0);
        check_a("rst_lo", 1'b1, 13'h0, 8'h03, 64'h0000_0000_0000_CAFE, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_a("rst_mid", 1'b0, 13'h0, 8'h00, 64'h0, 1'b0);
        check("rst_mid.ready", 64'(a_ready), 64'h1);
        tick();
        check("rst_after.we",   64'(a_we),   64'h0);
        check("rst_after.done", 64'(a_done), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
